// File: rtl/duart_rx_channel_if.sv
// Host-side bundle of the DUART receive channel: serial pin, enable,
// RHR pop / error clear strobes, and the head-of-FIFO status view.
interface duart_rx_channel_if #(
    parameter int FIFO_DEPTH = 3
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          rx;
    logic          rx_enable;
    logic          rd_strb;
    logic          clr_err;
    logic [7:0]    dout;
    logic          fe;
    logic          rx_rdy;
    logic          rx_ful;
    logic          ovr;
    logic [CW-1:0] count;

    // Register file / test host side
    modport master (
        output rx, rx_enable, rd_strb, clr_err,
        input  dout, fe, rx_rdy, rx_ful, ovr, count
    );

    // Receive channel side
    modport slave (
        input  rx, rx_enable, rd_strb, clr_err,
        output dout, fe, rx_rdy, rx_ful, ovr, count
    );
endinterface

// File: rtl/duart_rx_channel.sv
// 2681-style receive channel: 8N1 serial receiver feeding a small
// first-word-fall-through holding FIFO with sticky overrun.
module duart_rx_channel #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 3
) (
    input  logic                clk,
    input  logic                reset,
    duart_rx_channel_if.slave   bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_PTR = CW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Receiver state
    logic          sync_q, rs_q, prev_q;
    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          push_fe;

    // FIFO state
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          pop_ok, push_ok, overrun;

    // Frame FSM next-state: falling-edge arm, mid-bit sampling, stop check
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        push    = 1'b0;
        push_fe = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = tick_q;
                if (prev_q && !rs_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (tick_q == HALF_END) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    // A start bit that has gone high again by mid-bit is noise
                    state_d = rs_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == BIT_END) begin
                    tick_d  = '0;
                    shift_d = {rs_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick_q == BIT_END) begin
                    tick_d  = '0;
                    push    = 1'b1;
                    push_fe = !rs_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disabling the receiver throws away any partial frame
        if (!bus.rx_enable) begin
            state_d = IDLE;
            tick_d  = '0;
            push    = 1'b0;
        end
    end

    // FIFO bookkeeping: pop first so a full FIFO can accept a same-cycle push
    always_comb begin
        pop_ok   = bus.rd_strb && (count_q != '0);
        push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
        overrun  = push && !push_ok;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new overrun beats a simultaneous clear
        ovr_d = overrun ? 1'b1 : (bus.clr_err ? 1'b0 : ovr_q);
    end

    // All control state, synchronizer and FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 1'b1;
            rs_q     <= 1'b1;
            prev_q   <= 1'b1;
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            sync_q   <= bus.rx;
            rs_q     <= sync_q;
            prev_q   <= rs_q;
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    // Holding storage; contents are only visible through a non-zero count
    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem_q[wr_ptr_q] <= {push_fe, shift_q};
        end
    end

    assign bus.dout   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q][7:0];
    assign bus.fe     = (count_q == '0) ? 1'b0  : mem_q[rd_ptr_q][8];
    assign bus.rx_rdy = (count_q != '0);
    assign bus.rx_ful = (count_q == DEPTH_C);
    assign bus.ovr    = ovr_q;
    assign bus.count  = count_q;
endmodule
